// File: rtl/nes_pkg.sv
// Shared definitions for the cartridge loader/dumper: FSM states, mapper_flags
// field positions, SDRAM section bases and the iNES file magic.
package nes_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef enum logic {
        SECT_PRG = 1'b0,
        SECT_CHR = 1'b1
    } sect_e;

    // mapper_flags layout, identical to what the loader writes
    localparam int MAPPER_LSB       = 0;
    localparam int FLAG_MIRRORING   = 14;
    localparam int FLAG_CHR_RAM     = 15;
    localparam int FLAG_FOUR_SCREEN = 16;
    localparam int SUBMAPPER_LSB    = 17;
    localparam int FLAG_SAVES       = 25;
    localparam int PRGRAM_LSB       = 26;
    localparam int FLAG_PIANO       = 30;
    localparam int NVRAM_LSB        = 31;

    localparam logic [21:0] PRG_BASE = 22'h000000;
    localparam logic [21:0] CHR_BASE = 22'h200000;

    localparam logic [31:0] INES_MAGIC    = 32'h4E45531A;
    localparam logic [7:0]  EXP_DEV_PIANO = 8'h19;

endpackage

// File: rtl/ines_header_gen.sv
// Combinational iNES 2.0 header byte selector: returns header byte [idx]
// rebuilt from the mapper flags and page counts.
module ines_header_gen
    import nes_pkg::*;
(
    input  logic [63:0] flags,
    input  logic [7:0]  prg_pages,
    input  logic [7:0]  chr_pages,
    input  logic [3:0]  idx,
    output logic [7:0]  hdr_byte
);

    logic [7:0] mapper;
    logic       unused_flags;

    assign mapper = flags[MAPPER_LSB +: 8];
    assign unused_flags = ^{flags[63:NVRAM_LSB+4], flags[FLAG_CHR_RAM],
                            flags[FLAG_MIRRORING-1:MAPPER_LSB+8]};

    always_comb begin
        hdr_byte = 8'h00;
        case (idx)
            4'd0:  hdr_byte = INES_MAGIC[31:24];
            4'd1:  hdr_byte = INES_MAGIC[23:16];
            4'd2:  hdr_byte = INES_MAGIC[15:8];
            4'd3:  hdr_byte = INES_MAGIC[7:0];
            4'd4:  hdr_byte = prg_pages;
            4'd5:  hdr_byte = chr_pages;
            4'd6:  hdr_byte = {mapper[3:0], flags[FLAG_FOUR_SCREEN], 1'b0,
                               flags[FLAG_SAVES], flags[FLAG_MIRRORING]};
            // 2'b10 in bits 3:2 marks the file as NES 2.0
            4'd7:  hdr_byte = {mapper[7:4], 2'b10, 2'b00};
            4'd8:  hdr_byte = flags[SUBMAPPER_LSB +: 8];
            4'd10: hdr_byte = {flags[NVRAM_LSB +: 4], flags[PRGRAM_LSB +: 4]};
            4'd15: hdr_byte = flags[FLAG_PIANO] ? EXP_DEV_PIANO : 8'h00;
            default: hdr_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/rom_dumper.sv
// Streams the loaded cartridge back out as an iNES 2.0 file: 16 header bytes,
// then PRG and (if present) CHR read one byte at a time from SDRAM.
module rom_dumper
    import nes_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [63:0] mapper_flags,
    input  logic [7:0]  prg_pages,
    input  logic [7:0]  chr_pages,
    output logic [21:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_data,
    input  logic        mem_valid,
    output logic [7:0]  out_data,
    output logic        out_strobe,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_e        state_q, state_d;
    sect_e         sect_q, sect_d;
    logic [3:0]    ctr_q, ctr_d;
    logic [63:0]   flags_q, flags_d;
    logic [7:0]    prg_q, prg_d;
    logic [7:0]    chr_q, chr_d;
    logic [21:0]   addr_q, addr_d;
    logic [21:0]   left_q, left_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_strobe_q, out_strobe_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    logic [63:0]   hdr_flags;
    logic [7:0]    hdr_prg, hdr_chr, hdr_byte;
    logic [3:0]    hdr_idx;

    // Header bytes are registered one ahead: in IDLE byte 0 comes straight from
    // the inputs being latched, afterwards byte ctr+1 from the latched copy.
    assign hdr_flags = (state_q == ST_IDLE) ? mapper_flags : flags_q;
    assign hdr_prg   = (state_q == ST_IDLE) ? prg_pages    : prg_q;
    assign hdr_chr   = (state_q == ST_IDLE) ? chr_pages    : chr_q;
    assign hdr_idx   = (state_q == ST_IDLE) ? 4'd0         : ctr_q + 4'd1;

    ines_header_gen u_hdr (
        .flags     (hdr_flags),
        .prg_pages (hdr_prg),
        .chr_pages (hdr_chr),
        .idx       (hdr_idx),
        .hdr_byte  (hdr_byte)
    );

    always_comb begin
        state_d      = state_q;
        sect_d       = sect_q;
        ctr_d        = ctr_q;
        flags_d      = flags_q;
        prg_d        = prg_q;
        chr_d        = chr_q;
        addr_d       = addr_q;
        left_d       = left_q;
        tmo_d        = tmo_q;
        out_data_d   = out_data_q;
        out_strobe_d = out_strobe_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (prg_pages == 8'd0) begin
                        state_d = ST_ERROR;
                    end else begin
                        flags_d      = mapper_flags;
                        prg_d        = prg_pages;
                        chr_d        = chr_pages;
                        busy_d       = 1'b1;
                        done_d       = 1'b0;
                        error_d      = 1'b0;
                        ctr_d        = 4'd0;
                        out_data_d   = hdr_byte;
                        out_strobe_d = 1'b1;
                        state_d      = ST_HEADER;
                    end
                end
            end
            ST_HEADER: begin
                if (out_ready) begin
                    if (ctr_q == 4'd15) begin
                        out_strobe_d = 1'b0;
                        sect_d       = SECT_PRG;
                        addr_d       = PRG_BASE;
                        left_d       = {prg_q, 14'd0};
                        state_d      = ST_READ;
                    end else begin
                        ctr_d      = ctr_q + 4'd1;
                        out_data_d = hdr_byte;
                    end
                end
            end
            ST_READ: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_valid) begin
                    out_data_d   = mem_data;
                    out_strobe_d = 1'b1;
                    state_d      = ST_SEND;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    out_strobe_d = 1'b0;
                    addr_d       = addr_q + 22'd1;
                    left_d       = left_q - 22'd1;
                    if (left_q != 22'd1) begin
                        state_d = ST_READ;
                    end else if (sect_q == SECT_PRG && chr_q != 8'd0) begin
                        sect_d  = SECT_CHR;
                        addr_d  = CHR_BASE;
                        left_d  = {1'b0, chr_q, 13'd0};
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                error_d      = 1'b1;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                out_strobe_d = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            sect_q       <= SECT_PRG;
            ctr_q        <= 4'd0;
            flags_q      <= 64'd0;
            prg_q        <= 8'd0;
            chr_q        <= 8'd0;
            addr_q       <= 22'd0;
            left_q       <= 22'd0;
            tmo_q        <= '0;
            out_data_q   <= 8'd0;
            out_strobe_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sect_q       <= sect_d;
            ctr_q        <= ctr_d;
            flags_q      <= flags_d;
            prg_q        <= prg_d;
            chr_q        <= chr_d;
            addr_q       <= addr_d;
            left_q       <= left_d;
            tmo_q        <= tmo_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end

    assign mem_addr   = addr_q;
    assign mem_rd     = (state_q == ST_READ);
    assign out_data   = out_data_q;
    assign out_strobe = out_strobe_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_rom_dumper.sv
// Scoreboard bench for rom_dumper: expected bytes and read addresses are queued
// at start, a negedge monitor pops and compares them as the DUT produces them.
module tb_rom_dumper;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [63:0] mapper_flags = 64'd0;
    logic [7:0]  prg_pages = 8'd0;
    logic [7:0]  chr_pages = 8'd0;
    logic [21:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_data = 8'd0;
    logic        mem_valid = 1'b0;
    logic [7:0]  out_data;
    logic        out_strobe;
    logic        out_ready = 1'b1;
    logic        busy, done, error;

    int total = 0;
    int bad = 0;
    int rx_cnt = 0;
    int rd_cnt = 0;
    logic [21:0] chr_first = 22'h3FFFFF;

    logic [7:0]  exp_q[$];
    logic [21:0] exp_addr_q[$];

    bit          bp_en = 1'b0;
    bit          withhold = 1'b0;
    logic        pend = 1'b0;
    logic [21:0] pend_addr = 22'd0;
    logic        hold = 1'b0;
    logic [7:0]  hold_data = 8'd0;

    rom_dumper #(.TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .mapper_flags (mapper_flags),
        .prg_pages    (prg_pages),
        .chr_pages    (chr_pages),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_valid    (mem_valid),
        .out_data     (out_data),
        .out_strobe   (out_strobe),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    always #5 clk = ~clk;

    // SDRAM contents: mixes all address bits so a wrong section base shows up
    function automatic logic [7:0] mem_byte(input logic [21:0] a);
        return a[7:0] ^ a[15:8] ^ {2'b00, a[21:16]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic push_header(input logic [63:0] f, input logic [7:0] prg, input logic [7:0] chr);
        int mapper;
        int b6;
        int b7;
        int b10;
        mapper = int'(f[7:0]);
        b6  = (mapper % 16) * 16 + int'(f[16]) * 8 + int'(f[25]) * 2 + int'(f[14]);
        b7  = (mapper / 16) * 16 + 8;
        b10 = int'(f[34:31]) * 16 + int'(f[29:26]);
        exp_q.push_back(8'h4E);
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h53);
        exp_q.push_back(8'h1A);
        exp_q.push_back(prg);
        exp_q.push_back(chr);
        exp_q.push_back(8'(b6));
        exp_q.push_back(8'(b7));
        exp_q.push_back(f[24:17]);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'(b10));
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        exp_q.push_back(f[30] ? 8'h19 : 8'h00);
    endtask

    task automatic push_body(input logic [7:0] prg, input logic [7:0] chr);
        logic [21:0] a;
        for (int i = 0; i < int'(prg) * 16384; i++) begin
            a = 22'(i);
            exp_q.push_back(mem_byte(a));
            exp_addr_q.push_back(a);
        end
        for (int i = 0; i < int'(chr) * 8192; i++) begin
            a = 22'h200000 + 22'(i);
            exp_q.push_back(mem_byte(a));
            exp_addr_q.push_back(a);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_rd"}, 64'(mem_rd), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_out_strobe"}, 64'(out_strobe), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_error"}, 64'(error), 64'd0);
    endtask

    // memory: answers a read with valid data exactly one cycle after mem_rd
    always @(negedge clk) begin
        mem_valid = pend && !withhold;
        mem_data  = mem_byte(pend_addr);
        pend      = mem_rd;
        pend_addr = mem_addr;
    end

    always @(posedge clk) begin
        #1 out_ready = bp_en ? ($urandom_range(0, 7) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        logic [7:0]  e;
        logic [21:0] ea;
        if (!resetn) begin
            hold = 1'b0;
        end else begin
            if (hold) check("hold_stable", {55'd0, out_strobe, out_data}, {55'd0, 1'b1, hold_data});
            if (out_strobe && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", 64'(out_data), 64'h100);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("byte%0d", rx_cnt), 64'(out_data), 64'(e));
                end
                rx_cnt++;
            end
            if (mem_rd) begin
                rd_cnt++;
                if (rd_cnt == 16385) chr_first = mem_addr;
                if (exp_addr_q.size() == 0) begin
                    check("unexpected_read", 64'(mem_addr), 64'h400000);
                end else begin
                    ea = exp_addr_q.pop_front();
                    check($sformatf("rd_addr%0d", rd_cnt), 64'(mem_addr), 64'(ea));
                end
            end
            hold      = out_strobe && !out_ready;
            hold_data = out_data;
        end
    end

    initial begin
        logic [63:0] f;
        logic [7:0]  lit_hdr [16];
        bit          ok;
        int          lat;

        lit_hdr = '{8'h4E, 8'h45, 8'h53, 8'h1A, 8'h02, 8'h01, 8'h43, 8'h08,
                    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        // reset values
        repeat (3) @(posedge clk);
        #1 check_reset_vals("rst");
        @(negedge clk) resetn = 1'b1;
        repeat (2) @(posedge clk);

        // zero PRG pages: straight to error, no stream
        prg_pages = 8'd0;
        chr_pages = 8'd3;
        pulse_start();
        check("prg0_err_cycle1", 64'(error), 64'd0);
        check("prg0_busy_cycle1", 64'(busy), 64'd0);
        @(posedge clk); #1;
        check("prg0_error", 64'(error), 64'd1);
        check("prg0_done", 64'(done), 64'd1);
        check("prg0_busy", 64'(busy), 64'd0);
        check("prg0_strobe", 64'(out_strobe), 64'd0);
        repeat (3) @(posedge clk);

        // known header, then reset at byte 100
        f = {$urandom, $urandom};
        f[7:0]   = 8'd4;
        f[14]    = 1'b1;
        f[16]    = 1'b0;
        f[24:17] = 8'd0;
        f[25]    = 1'b1;
        f[34:26] = 9'd0;
        mapper_flags = f;
        prg_pages = 8'd2;
        chr_pages = 8'd1;
        for (int i = 0; i < 16; i++) exp_q.push_back(lit_hdr[i]);
        push_body(8'd2, 8'd1);
        rx_cnt = 0;
        rd_cnt = 0;
        check("hdr_busy_pre", 64'(busy), 64'd0);
        pulse_start();
        check("hdr_busy_first", 64'(busy), 64'd1);
        check("hdr_strobe_first", 64'(out_strobe), 64'd1);
        check("hdr_done_cleared", 64'(done), 64'd0);
        check("hdr_error_cleared", 64'(error), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rx_cnt >= 100) begin ok = 1'b1; break; end
        end
        check("reach_byte100", 64'(ok), 64'd1);
        @(posedge clk); #2 resetn = 1'b0;
        #1 check_reset_vals("midrst");
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1 check_reset_vals("postrst");

        // full stream with random flags and back-pressure
        f = {$urandom, $urandom};
        mapper_flags = f;
        prg_pages = 8'd1;
        chr_pages = 8'd1;
        push_header(f, 8'd1, 8'd1);
        push_body(8'd1, 8'd1);
        rx_cnt = 0;
        rd_cnt = 0;
        bp_en = 1'b1;
        pulse_start();
        repeat (500) @(posedge clk);
        prg_pages = 8'd0;
        mapper_flags = ~f;
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 95000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        check("full_done", 64'(ok), 64'd1);
        check("full_error", 64'(error), 64'd0);
        check("full_busy", 64'(busy), 64'd0);
        check("full_count", 64'(rx_cnt), 64'd24592);
        check("full_left", 64'(exp_q.size()), 64'd0);
        check("full_rd_left", 64'(exp_addr_q.size()), 64'd0);
        check("chr_first_addr", 64'(chr_first), 64'h200000);
        bp_en = 1'b0;
        repeat (3) @(posedge clk);

        // memory never answers: timeout abort after the header
        withhold = 1'b1;
        f = {$urandom, $urandom};
        mapper_flags = f;
        prg_pages = 8'd1;
        chr_pages = 8'd0;
        push_header(f, 8'd1, 8'd0);
        exp_addr_q.push_back(22'd0);
        rx_cnt = 0;
        rd_cnt = 0;
        pulse_start();
        check("tmo_done_cleared", 64'(done), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (mem_rd) begin ok = 1'b1; break; end
        end
        check("tmo_read_seen", 64'(ok), 64'd1);
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            @(negedge clk);
            lat++;
            if (error) begin ok = 1'b1; break; end
        end
        check("tmo_error", 64'(ok), 64'd1);
        check("tmo_latency_in_range", 64'(lat >= TIMEOUT && lat <= TIMEOUT + 3), 64'd1);
        check("tmo_done", 64'(done), 64'd1);
        check("tmo_busy", 64'(busy), 64'd0);
        check("tmo_strobe", 64'(out_strobe), 64'd0);
        check("tmo_hdr_count", 64'(rx_cnt), 64'd16);
        check("tmo_left", 64'(exp_q.size()), 64'd0);
        withhold = 1'b0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rom_dumper.md
# rom_dumper

Streams a loaded cartridge image back out of SDRAM as an iNES 2.0 file, byte by byte. It is the inverse of the game loader. The block rebuilds the 16-byte header from the active `mapper_flags` and page counts, then reads PRG (base 0x000000) and CHR (base 0x200000) through a single-outstanding memory read port. Bytes leave on a valid/ready byte stream toward the host upload path.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles to wait for `mem_valid` after a `mem_rd` before aborting.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a dump; ignored while `busy`
- mapper_flags  in  64  current mapper flags, same field layout the loader produces
- prg_pages  in  8  PRG size in 16 KiB units
- chr_pages  in  8  CHR size in 8 KiB units; 0 means CHR RAM, no CHR section
- mem_addr  out  22  read address
- mem_rd  out  1  one-cycle read request
- mem_data  in  8  read data
- mem_valid  in  1  `mem_data` valid; at least 1 cycle after `mem_rd`
- out_data  out  8  stream byte
- out_strobe  out  1  `out_data` valid
- out_ready  in  1  sink accepts the byte on `out_strobe && out_ready`
- busy  out  1  dump in progress
- done  out  1  sticky completion flag; cleared by the next accepted `start`
- error  out  1  sticky abort flag; cleared by the next accepted `start`

## Operation
- States: IDLE, HEADER, READ, WAIT, SEND, DONE, ERROR.
- A 1-bit section register selects PRG or CHR.

IDLE:
- On `start`:
  - if `prg_pages`==0, go to ERROR;
  - otherwise latch `mapper_flags`, `prg_pages` and `chr_pages`, set `busy`=1, clear `done`/`error`, set ctr=0, and go to HEADER.

HEADER:
- `out_strobe`=1 with header byte[ctr]; ctr advances on each handshake.
- Header bytes:
  - bytes 0-3: 4E 45 53 1A.
  - byte 4: `prg_pages`.
  - byte 5: `chr_pages`.
  - byte 6: {mapper[3:0], flags[16], 1'b0, flags[25], flags[14]}.
  - byte 7: {mapper[7:4], 2'b10, 2'b00}.
  - byte 8: flags[24:17].
  - byte 9: 00.
  - byte 10: {flags[34:31], flags[29:26]}.
  - bytes 11-14: 00.
  - byte 15: flags[30] ? 19 : 00.
- After byte 15 is accepted: section=PRG, `mem_addr`=0, bytes_left = `prg_pages`<<14 (22 bits), go to READ.

READ:
- Pulse `mem_rd` for 1 cycle at `mem_addr`, clear the timeout counter, go to WAIT.

WAIT:
- On `mem_valid`: capture `mem_data` into the output register, go to SEND.
- If the counter reaches TIMEOUT first, go to ERROR.

SEND:
- `out_strobe`=1, holding the captured byte until `out_ready`.
- On handshake: `mem_addr`+1, bytes_left-1.
  - If bytes_left now nonzero, go to READ.
  - Else if section=PRG and `chr_pages`!=0: section=CHR, `mem_addr`=0x200000, bytes_left = `chr_pages`<<13, go to READ.
  - Else go to DONE.

DONE:
- Set `done`=1 and `busy`=0, go to IDLE.

ERROR:
- Set `error`=1, `done`=1 and `busy`=0; drop `out_strobe`; go to IDLE.

Other rules:
- `mem_valid` outside WAIT is ignored.
- `mem_addr` wraps at 22 bits; no sizes allowed by the 8-bit page counts reach the wrap.

## Timing
- Reset values: state IDLE; `mem_addr`=0, `mem_rd`=0, `out_data`=0, `out_strobe`=0, `busy`=0, `done`=0, `error`=0; ctr=0.
- `busy` and the first header `out_strobe` rise the cycle after `start`.
- Header throughput: 1 byte/cycle while `out_ready`=1.
- Body throughput: minimum 3 cycles/byte (READ, WAIT with same-next-cycle `mem_valid`, SEND with `out_ready`=1).
- `out_data` and `out_strobe` are registered and stable while `out_ready`=0.
- `start` during `busy` has no effect.
- Reset asserted mid-dump returns immediately to reset values; any in-flight `mem_valid` after reset release is ignored.

## Structure
- Shared package `nes_pkg`:
  - state enum;
  - `mapper_flags` field bit positions (mirroring 14, chr_ram 15, four_screen 16, submapper 24:17, saves 25, prgram 29:26, piano 30, nvram 34:31);
  - PRG base 0x000000 and CHR base 0x200000;
  - iNES magic constant.
- The header byte multiplexer is natural as sub-module `ines_header_gen`: combinational, inputs flags/page counts/index, output byte.

## Test plan
- Header: mapper_flags with mapper=4, mirroring=1, saves=1, submapper=0, prg_pages=2, chr_pages=1, `out_ready`=1 → first 16 bytes are 4E 45 53 1A 02 01 43 08 00 00 00 00 00 00 00 00.
- Full stream: prg_pages=1, chr_pages=1, memory model returns low address byte 1 cycle after `mem_rd` → 16+16384+8192 bytes; the first CHR read is at `mem_addr`=0x200000; `done`=1, `error`=0.
- CHR RAM: chr_pages=0 → exactly 16+16384 bytes, no read above 0x003FFF.
- Back-pressure: random `out_ready` toggling → `out_data` never changes while `out_strobe`=1 and `out_ready`=0; the byte sequence is identical to the full-stream case.
- Errors:
  - prg_pages=0 → no `out_strobe`; `error`=`done`=1 two cycles after `start`.
  - `mem_valid` withheld → `error`=1 after TIMEOUT cycles in WAIT.
- Reset mid-dump at byte 100, then new `start` → all outputs return to reset values, and the next dump restarts from header byte 0.
